// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad digit collection, submit strobe and lockout policy
//
// Purpose: accepts debounced key presses, assembles up to three BCD digits into
// a 12-bit code, strobes the password comparator with a compare pulse, and
// applies clear, short-entry, inactivity-timeout and wrong-code lockout policy.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   key_valid  in   debounced key-held level
//   key_code   in   4-bit key: 0-9 digit, A clear, B enter, C-F ignored
//   lock       in   comparator result, 1 = match
//   pass_in    out  entered code, first digit in [11:8]
//   enb        out  compare pulse, PULSE_CYCLES wide
//   digit_cnt  out  digits held, 0-3
//   short_err  out  one-cycle pulse on enter with fewer than 3 digits
//   timeout    out  one-cycle pulse when a partial entry is discarded
//   locked_out out  high during lockout

module keypad_entry #(
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 500_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        lock,
  output logic [11:0] pass_in,
  output logic        enb,
  output logic [1:0]  digit_cnt,
  output logic        short_err,
  output logic        timeout,
  output logic        locked_out
);

  // Counters only ever hold 0..LIMIT-1, so $clog2(LIMIT) bits never wrap.
  localparam int PW = (PULSE_CYCLES   > 1) ? $clog2(PULSE_CYCLES)   : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = (MAX_FAILS      > 1) ? $clog2(MAX_FAILS)      : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAILS - 1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_FULL,
    S_SUBMIT,
    S_LOCKOUT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_key_prev;
  logic [11:0]   r_pass, w_pass_nxt;
  logic [1:0]    r_cnt, w_cnt_nxt;
  logic          r_enb, w_enb_nxt;
  logic          r_short, w_short_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [FW-1:0] r_fails, w_fails_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [PW-1:0] r_pulse, w_pulse_nxt;
  logic [LW-1:0] r_lock_tmr, w_lock_tmr_nxt;

  logic w_accept;
  logic w_is_digit;
  logic w_is_clear;
  logic w_is_enter;

  // A press is the rising edge of key_valid; key_prev powers up high so a key
  // held through reset release is not taken as a new press.
  assign w_accept   = key_valid & ~r_key_prev;
  assign w_is_digit = (key_code <= 4'd9);
  assign w_is_clear = (key_code == 4'hA);
  assign w_is_enter = (key_code == 4'hB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_key_prev <= 1'b1;
      r_pass     <= '0;
      r_cnt      <= '0;
      r_enb      <= 1'b0;
      r_short    <= 1'b0;
      r_timeout  <= 1'b0;
      r_fails    <= '0;
      r_timer    <= '0;
      r_pulse    <= '0;
      r_lock_tmr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_key_prev <= key_valid;
      r_pass     <= w_pass_nxt;
      r_cnt      <= w_cnt_nxt;
      r_enb      <= w_enb_nxt;
      r_short    <= w_short_nxt;
      r_timeout  <= w_timeout_nxt;
      r_fails    <= w_fails_nxt;
      r_timer    <= w_timer_nxt;
      r_pulse    <= w_pulse_nxt;
      r_lock_tmr <= w_lock_tmr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pass_nxt     = r_pass;
    w_cnt_nxt      = r_cnt;
    w_enb_nxt      = r_enb;
    w_short_nxt    = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_fails_nxt    = r_fails;
    w_timer_nxt    = r_timer;
    w_pulse_nxt    = r_pulse;
    w_lock_tmr_nxt = r_lock_tmr;

    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (w_accept) begin
          if (w_is_digit) begin
            w_pass_nxt  = {r_pass[7:0], key_code};
            w_cnt_nxt   = 2'd1;
            w_state_nxt = S_ENTRY;
          end else if (w_is_enter) begin
            w_short_nxt = 1'b1;
          end
        end
      end

      S_ENTRY, S_FULL: begin
        // A press (even an ignored one) wins over expiry in the same cycle.
        if (w_accept) begin
          w_timer_nxt = '0;
          if (w_is_digit) begin
            if (r_state == S_ENTRY) begin
              w_pass_nxt = {r_pass[7:0], key_code};
              w_cnt_nxt  = r_cnt + 2'd1;
              if (r_cnt == 2'd2) begin
                w_state_nxt = S_FULL;
              end
            end
          end else if (w_is_clear) begin
            w_pass_nxt  = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else if (w_is_enter) begin
            if (r_state == S_FULL) begin
              w_enb_nxt   = 1'b1;
              w_pulse_nxt = '0;
              w_state_nxt = S_SUBMIT;
            end else begin
              w_short_nxt = 1'b1;
              w_pass_nxt  = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
            end
          end
        end else if (r_timer == TIMER_LAST) begin
          w_timeout_nxt = 1'b1;
          w_pass_nxt    = '0;
          w_cnt_nxt     = '0;
          w_timer_nxt   = '0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end

      S_SUBMIT: begin
        // pass_in is held for the whole pulse; lock is read on its final cycle.
        if (r_pulse == PULSE_LAST) begin
          w_enb_nxt  = 1'b0;
          w_pass_nxt = '0;
          w_cnt_nxt  = '0;
          if (lock) begin
            w_fails_nxt = '0;
            w_state_nxt = S_IDLE;
          end else if (r_fails == FAIL_LAST) begin
            w_fails_nxt    = '0;
            w_lock_tmr_nxt = '0;
            w_state_nxt    = S_LOCKOUT;
          end else begin
            w_fails_nxt = r_fails + FW'(1);
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_pulse_nxt = r_pulse + PW'(1);
        end
      end

      S_LOCKOUT: begin
        if (r_lock_tmr == LOCK_LAST) begin
          w_lock_tmr_nxt = '0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_lock_tmr_nxt = r_lock_tmr + LW'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign pass_in    = r_pass;
  assign enb        = r_enb;
  assign digit_cnt  = r_cnt;
  assign short_err  = r_short;
  assign timeout    = r_timeout;
  assign locked_out = (r_state == S_LOCKOUT);

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - scoreboard bench for keypad_entry

module tb_keypad_entry;

  localparam int P      = 2;
  localparam int T      = 20;
  localparam int MF     = 3;
  localparam int L      = 30;
  localparam int SECRET = 'h123;

  localparam int K_RISE  = 0;
  localparam int K_FALL  = 1;
  localparam int K_SHORT = 2;
  localparam int K_TMO   = 3;
  localparam int K_LRISE = 4;
  localparam int K_LFALL = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        lock = 1'b0;
  logic [11:0] pass_in;
  logic        enb;
  logic [1:0]  digit_cnt;
  logic        short_err;
  logic        timeout;
  logic        locked_out;

  keypad_entry #(
    .PULSE_CYCLES  (P),
    .TIMEOUT_CYCLES(T),
    .MAX_FAILS     (MF),
    .LOCKOUT_CYCLES(L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .lock      (lock),
    .pass_in   (pass_in),
    .enb       (enb),
    .digit_cnt (digit_cnt),
    .short_err (short_err),
    .timeout   (timeout),
    .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int c;
    int pass;
    int cnt;
  } data_ev_t;

  data_ev_t q_data[$];
  int q_rise[$], q_rise_pass[$], q_fall[$], q_short[$], q_tmo[$], q_lrise[$], q_lfall[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (entry as a digit list, busy windows as times)
  int  digits[$];
  int  m_cyc = 0;
  bit  m_prev = 1'b1;
  int  m_fail = 0;
  int  m_last = 0;
  int  m_sub_end = 0;
  int  m_lock_end = 0;
  bit  m_match = 1'b0;

  function automatic int code_val();
    int v = 0;
    foreach (digits[i]) v = v * 16 + digits[i];
    return v;
  endfunction

  task automatic push_data(input int n);
    data_ev_t d;
    d.c = n;
    d.pass = code_val();
    d.cnt = digits.size();
    q_data.push_back(d);
  endtask

  task automatic model_edge(input bit kv, input logic [3:0] kc);
    int n;
    bit acc;
    n = m_cyc + 1;
    m_cyc = n;
    acc = kv && !m_prev;
    m_prev = kv;
    if (n <= m_sub_end) begin
      if (n == m_sub_end) begin
        q_fall.push_back(n);
        digits.delete();
        push_data(n);
        if (m_match) m_fail = 0;
        else if (m_fail + 1 == MF) begin
          m_fail = 0;
          m_lock_end = n + L;
          q_lrise.push_back(n);
        end else m_fail++;
      end
      return;
    end
    if (n <= m_lock_end) begin
      if (n == m_lock_end) q_lfall.push_back(n);
      return;
    end
    if (acc) begin
      m_last = n;
      if (kc <= 4'd9) begin
        if (digits.size() < 3) begin
          digits.push_back(int'(kc));
          push_data(n);
        end
      end else if (kc == 4'hA) begin
        if (digits.size() > 0) begin
          digits.delete();
          push_data(n);
        end
      end else if (kc == 4'hB) begin
        if (digits.size() == 3) begin
          m_match = (code_val() == SECRET);
          m_sub_end = n + P;
          q_rise.push_back(n);
          q_rise_pass.push_back(code_val());
        end else begin
          q_short.push_back(n);
          if (digits.size() > 0) begin
            digits.delete();
            push_data(n);
          end
        end
      end
    end else if (digits.size() > 0 && n - m_last == T) begin
      q_tmo.push_back(n);
      digits.delete();
      push_data(n);
    end
  endtask

  task automatic model_reset();
    m_cyc = cyc;
    m_prev = 1'b1;
    digits.delete();
    m_fail = 0;
    m_last = 0;
    m_sub_end = 0;
    m_lock_end = 0;
    m_match = 1'b0;
  endtask

  // ---------------- stimulus helpers
  task automatic step(input bit kv, input logic [3:0] kc);
    // lock carries the comparator answer only on the sampling edge; noise otherwise.
    if (m_cyc + 1 == m_sub_end) lock = m_match;
    else lock = 1'($urandom_range(0, 1));
    key_valid = kv;
    key_code = kv ? kc : 4'($urandom_range(0, 15));
    model_edge(kv, kc);
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] kc);
    int h = $urandom_range(1, 3);
    int g = $urandom_range(1, 3);
    repeat (h) step(1'b1, kc);
    repeat (g) step(1'b0, 4'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0);
  endtask

  task automatic submit3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    press(a);
    press(b);
    press(c);
    press(4'hB);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pass_in"}, pass_in, 0);
    chk({tag, "_enb"}, enb, 0);
    chk({tag, "_digit_cnt"}, digit_cnt, 0);
    chk({tag, "_short_err"}, short_err, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_locked_out"}, locked_out, 0);
  endtask

  // ---------------- monitor
  task automatic mon_ev(input int k, input string name);
    int has;
    int exp;
    has = 0;
    exp = 0;
    case (k)
      K_RISE:  begin has = q_rise.size();  if (has > 0) exp = q_rise.pop_front();  end
      K_FALL:  begin has = q_fall.size();  if (has > 0) exp = q_fall.pop_front();  end
      K_SHORT: begin has = q_short.size(); if (has > 0) exp = q_short.pop_front(); end
      K_TMO:   begin has = q_tmo.size();   if (has > 0) exp = q_tmo.pop_front();   end
      K_LRISE: begin has = q_lrise.size(); if (has > 0) exp = q_lrise.pop_front(); end
      default: begin has = q_lfall.size(); if (has > 0) exp = q_lfall.pop_front(); end
    endcase
    if (has == 0) begin
      total++;
      bad++;
      $display("FAIL %s: unexpected event at cycle %0d, none expected", name, cyc);
    end else begin
      chk({name, "_cycle"}, cyc, exp);
    end
  endtask

  initial begin
    logic        p_enb;
    logic        p_lock;
    logic [11:0] p_pass;
    logic [1:0]  p_cnt;
    data_ev_t    d;
    p_enb = 1'b0;
    p_lock = 1'b0;
    p_pass = '0;
    p_cnt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_enb = 1'b0;
        p_lock = 1'b0;
        p_pass = '0;
        p_cnt = '0;
      end else begin
        if (pass_in !== p_pass || digit_cnt !== p_cnt) begin
          if (q_data.size() == 0) begin
            total++;
            bad++;
            $display("FAIL data_change: unexpected pass_in=%0h digit_cnt=%0d at cycle %0d", pass_in, digit_cnt, cyc);
          end else begin
            d = q_data.pop_front();
            chk("data_cycle", cyc, d.c);
            chk("pass_in", int'(pass_in), d.pass);
            chk("digit_cnt", int'(digit_cnt), d.cnt);
          end
          p_pass = pass_in;
          p_cnt = digit_cnt;
        end
        if (enb && !p_enb) begin
          mon_ev(K_RISE, "enb_rise");
          if (q_rise_pass.size() > 0) chk("enb_pass_in", int'(pass_in), q_rise_pass.pop_front());
        end
        if (!enb && p_enb) mon_ev(K_FALL, "enb_fall");
        if (short_err) mon_ev(K_SHORT, "short_err");
        if (timeout) mon_ev(K_TMO, "timeout");
        if (locked_out && !p_lock) mon_ev(K_LRISE, "lockout_rise");
        if (!locked_out && p_lock) mon_ev(K_LFALL, "lockout_fall");
        p_enb = enb;
        p_lock = locked_out;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    model_reset();
    idle(3);

    // correct code
    submit3(4'd1, 4'd2, 4'd3);
    idle(4);

    // short entry, clear, overflow digit
    press(4'd4); press(4'd5); press(4'hB);
    press(4'hB);
    press(4'd7); press(4'd8); press(4'hA);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hA);

    // inactivity timeout, then a key landing on the expiry edge
    press(4'd9);
    idle(25);
    step(1'b1, 4'd9);
    repeat (T - 1) step(1'b0, 4'd0);
    step(1'b1, 4'd5);
    step(1'b0, 4'd0);
    press(4'hA);

    // lockout after three wrong codes; keys ignored during it
    repeat (3) submit3(4'd0, 4'd0, 4'd0);
    repeat (6) press(4'($urandom_range(0, 11)));
    idle(L + 5);
    submit3(4'd1, 4'd2, 4'd3);
    idle(3);

    // fail, fail, match, fail: no lockout
    submit3(4'd0, 4'd0, 4'd0);
    submit3(4'd0, 4'd0, 4'd0);
    submit3(4'd1, 4'd2, 4'd3);
    submit3(4'd0, 4'd0, 4'd0);
    idle(3);
    submit3(4'd1, 4'd2, 4'd3);
    idle(3);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: submit3(4'd1, 4'd2, 4'd3);
        1: submit3(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
        2: press(4'($urandom_range(0, 15)));
        3: idle($urandom_range(0, 24));
        4: press(4'($urandom_range(0, 9)));
        default: press(4'hA);
      endcase
    end
    idle(L + 10);

    // reset mid compare pulse, key held across release
    press(4'hA);
    idle(T + 2);
    press(4'd1); press(4'd2); press(4'd3);
    step(1'b1, 4'hB);
    step(1'b1, 4'hB);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    chk("pending_at_reset", q_data.size() + q_rise.size() + q_short.size() + q_tmo.size(), 0);
    key_valid = 1'b1;
    key_code = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (4) step(1'b1, 4'd7);
    step(1'b0, 4'd0);
    press(4'd4);
    press(4'hA);
    idle(5);

    chk("left_data", q_data.size(), 0);
    chk("left_enb_rise", q_rise.size(), 0);
    chk("left_enb_fall", q_fall.size(), 0);
    chk("left_short", q_short.size(), 0);
    chk("left_timeout", q_tmo.size(), 0);
    chk("left_lock_rise", q_lrise.size(), 0);
    chk("left_lock_fall", q_lfall.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
